unidade_controle: RTL and testbench

Multi-cycle control unit for the 16-bit datapath. It fetches instructions from a synchronous instruction memory and holds the program counter. It decodes each instruction and drives the register-bank selects, write enable, ALU operation and write-back mux. It sits directly upstream of the register bank and is the only source of its Hab_Escrita, Sel_E_SA and Sel_SB inputs.

---
 rtl/unidade_controle_if.sv | 28 ++
 rtl/unidade_controle.sv | 192 +++++++++++++++++++
 tb/tb_unidade_controle.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_if.sv
// Bus between the control unit, the synchronous instruction memory and the register bank.
// master: control unit side; slave: memory / register bank side.
interface unidade_controle_if #(
  parameter int bits_palavra  = 16,
  parameter int bits_pc       = 8,
  parameter int end_registros = 2
);
  logic [bits_palavra-1:0]  Instrucao;
  logic [bits_palavra-1:0]  A;
  logic [bits_pc-1:0]       Endereco;
  logic                     Hab_Escrita;
  logic [end_registros-1:0] Sel_E_SA;
  logic [end_registros-1:0] Sel_SB;
  logic [2:0]               Op_ULA;
  logic                     Sel_Mux;
  logic [bits_palavra-1:0]  Imediato;
  logic                     Parado;

  modport master (
    input  Instrucao, A,
    output Endereco, Hab_Escrita, Sel_E_SA, Sel_SB, Op_ULA, Sel_Mux, Imediato, Parado
  );

  modport slave (
    output Instrucao, A,
    input  Endereco, Hab_Escrita, Sel_E_SA, Sel_SB, Op_ULA, Sel_Mux, Imediato, Parado
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle (BUSCA/DECODIFICA/EXECUTA/ESCRITA) control unit for the 16-bit datapath.
// Control outputs are registered from the next state and next IR, so they only depend on flops.
module unidade_controle #(
  parameter int bits_palavra  = 16,
  parameter int bits_pc       = 8,
  parameter int end_registros = 2
) (
  input  logic                clock,
  input  logic                reset,
  unidade_controle_if.master  bus
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    ESCRITA    = 3'd3,
    PARADO     = 3'd4
  } estado_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [bits_pc-1:0] PC_UM = {{(bits_pc-1){1'b0}}, 1'b1};

  estado_t                   estado_r;
  estado_t                   estado_nx_s;
  logic [bits_pc-1:0]        pc_r;
  logic [bits_palavra-1:0]   ir_r;
  logic [bits_palavra-1:0]   ir_nx_s;
  logic                      z_r;

  logic                      hab_escrita_s, hab_escrita_r;
  logic [end_registros-1:0]  sel_e_sa_s, sel_e_sa_r;
  logic [end_registros-1:0]  sel_sb_s, sel_sb_r;
  logic [2:0]                op_ula_s, op_ula_r;
  logic                      sel_mux_s, sel_mux_r;
  logic [bits_palavra-1:0]   imediato_s, imediato_r;
  logic                      parado_s, parado_r;

  function automatic logic [2:0] decodifica_ula(input logic [3:0] opc);
    case (opc)
      OP_ADD:  decodifica_ula = 3'd0;
      OP_SUB:  decodifica_ula = 3'd1;
      OP_AND:  decodifica_ula = 3'd2;
      OP_OR:   decodifica_ula = 3'd3;
      OP_MOV:  decodifica_ula = 3'd4;
      default: decodifica_ula = 3'd0;
    endcase
  endfunction

  function automatic logic escreve_registro(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_MOV: escreve_registro = 1'b1;
      default:                                       escreve_registro = 1'b0;
    endcase
  endfunction

  // NOP and the undefined opcodes 9..E leave Imediato at zero.
  function automatic logic opcode_decodificado(input logic [3:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_MOV,
      OP_JMP, OP_BEQZ, OP_HALT: opcode_decodificado = 1'b1;
      default:                  opcode_decodificado = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r <= BUSCA;
    end else begin
      estado_r <= estado_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    estado_nx_s = estado_r;
    case (estado_r)
      BUSCA:      estado_nx_s = DECODIFICA;
      DECODIFICA: estado_nx_s = EXECUTA;
      EXECUTA:    estado_nx_s = ESCRITA;
      ESCRITA: begin
        if (ir_r[15:12] == OP_HALT) begin
          estado_nx_s = PARADO;
        end else begin
          estado_nx_s = BUSCA;
        end
      end
      PARADO:     estado_nx_s = PARADO;
      default:    estado_nx_s = BUSCA;
    endcase
  end

  // IR value seen by the next cycle: memory data is captured only in DECODIFICA
  always_comb begin
    ir_nx_s = ir_r;
    if (estado_r == DECODIFICA) begin
      ir_nx_s = bus.Instrucao;
    end else begin
      ir_nx_s = ir_r;
    end
  end

  // Output decode for the upcoming cycle, registered below
  always_comb begin
    hab_escrita_s = 1'b0;
    sel_e_sa_s    = '0;
    sel_sb_s      = '0;
    op_ula_s      = 3'd0;
    sel_mux_s     = 1'b0;
    imediato_s    = '0;
    parado_s      = 1'b0;
    case (estado_nx_s)
      EXECUTA, ESCRITA: begin
        sel_e_sa_s    = ir_nx_s[11:10];
        sel_sb_s      = ir_nx_s[9:8];
        op_ula_s      = decodifica_ula(ir_nx_s[15:12]);
        sel_mux_s     = (ir_nx_s[15:12] == OP_LDI);
        hab_escrita_s = (estado_nx_s == ESCRITA) && escreve_registro(ir_nx_s[15:12]);
        if (opcode_decodificado(ir_nx_s[15:12])) begin
          imediato_s = {{(bits_palavra-8){1'b0}}, ir_nx_s[7:0]};
        end else begin
          imediato_s = '0;
        end
      end
      PARADO:  parado_s = 1'b1;
      default: parado_s = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      hab_escrita_r <= 1'b0;
      sel_e_sa_r    <= '0;
      sel_sb_r      <= '0;
      op_ula_r      <= 3'd0;
      sel_mux_r     <= 1'b0;
      imediato_r    <= '0;
      parado_r      <= 1'b0;
    end else begin
      hab_escrita_r <= hab_escrita_s;
      sel_e_sa_r    <= sel_e_sa_s;
      sel_sb_r      <= sel_sb_s;
      op_ula_r      <= op_ula_s;
      sel_mux_r     <= sel_mux_s;
      imediato_r    <= imediato_s;
      parado_r      <= parado_s;
    end
  end

  // IR, zero flag and PC; the PC only moves at the end of ESCRITA
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= '0;
      ir_r <= '0;
      z_r  <= 1'b0;
    end else begin
      ir_r <= ir_nx_s;
      if (estado_r == EXECUTA && ir_r[15:12] == OP_BEQZ) begin
        z_r <= (bus.A == '0);
      end
      if (estado_r == ESCRITA) begin
        case (ir_r[15:12])
          OP_JMP:  pc_r <= bits_pc'(ir_r[7:0]);
          OP_BEQZ: pc_r <= z_r ? bits_pc'(ir_r[7:0]) : pc_r + PC_UM;
          OP_HALT: pc_r <= pc_r;
          default: pc_r <= pc_r + PC_UM;
        endcase
      end
    end
  end

  assign bus.Endereco    = pc_r;
  assign bus.Hab_Escrita = hab_escrita_r;
  assign bus.Sel_E_SA    = sel_e_sa_r;
  assign bus.Sel_SB      = sel_sb_r;
  assign bus.Op_ULA      = op_ula_r;
  assign bus.Sel_Mux     = sel_mux_r;
  assign bus.Imediato    = imediato_r;
  assign bus.Parado      = parado_r;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with an instruction memory and register bank model.
module tb_unidade_controle;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cyc;

  logic [15:0] imem [0:255];
  logic [15:0] regs [0:3];
  logic [15:0] r0_init;
  logic [15:0] ula_s;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: data for Endereco appears one cycle later
  always @(posedge clock) bus.Instrucao <= imem[bus.Endereco];

  // Reference ALU and register bank
  always_comb begin
    ula_s = 16'h0000;
    case (bus.Op_ULA)
      3'd0:    ula_s = bus.A + regs[bus.Sel_SB];
      3'd1:    ula_s = bus.A - regs[bus.Sel_SB];
      3'd2:    ula_s = bus.A & regs[bus.Sel_SB];
      3'd3:    ula_s = bus.A | regs[bus.Sel_SB];
      3'd4:    ula_s = regs[bus.Sel_SB];
      default: ula_s = 16'h0000;
    endcase
  end

  always @(posedge clock) begin
    if (reset) begin
      regs[0] <= r0_init;
      regs[1] <= 16'h0000;
      regs[2] <= 16'h0000;
      regs[3] <= 16'h0000;
    end else if (bus.Hab_Escrita) begin
      regs[bus.Sel_E_SA] <= bus.Sel_Mux ? bus.Imediato : ula_s;
    end
  end

  assign bus.A = regs[bus.Sel_E_SA];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic limpa();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic reinicia();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic avancar(input int n);
    repeat (n) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    r0_init     = 16'h0000;

    // LDI r1,5 ; LDI r2,3 ; ADD r1,r2
    limpa();
    imem[0] = 16'h5405;
    imem[1] = 16'h5803;
    imem[2] = 16'h1600;
    imem[3] = 16'hF000;
    reinicia();
    chk("rst_endereco", 32'(bus.Endereco), 32'h0);
    chk("rst_parado",   32'(bus.Parado),   32'h0);
    chk("rst_op_ula",   32'(bus.Op_ULA),   32'h0);
    chk("rst_imediato", 32'(bus.Imediato), 32'h0);
    chk("rst_sel_e_sa", 32'(bus.Sel_E_SA), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      chk("hab_pulse", 32'(bus.Hab_Escrita), 32'((k % 4) == 0));
      if (k == 2) chk("decod_sel_e_sa", 32'(bus.Sel_E_SA), 32'h0);
      if (k == 4) begin
        chk("ldi_imediato", 32'(bus.Imediato), 32'h5);
        chk("ldi_sel_mux",  32'(bus.Sel_Mux),  32'h1);
        chk("ldi_sel_e_sa", 32'(bus.Sel_E_SA), 32'h1);
      end
      if (k == 12) begin
        chk("add_sel_e_sa", 32'(bus.Sel_E_SA), 32'h1);
        chk("add_sel_sb",   32'(bus.Sel_SB),   32'h2);
        chk("add_op_ula",   32'(bus.Op_ULA),   32'h0);
        chk("add_sel_mux",  32'(bus.Sel_Mux),  32'h0);
      end
      if (k < 12) avancar(1);
    end
    avancar(1);
    chk("add_pc", 32'(bus.Endereco), 32'h3);
    chk("add_r1", 32'(regs[1]),      32'h8);

    // LDI r1,C ; LDI r2,A ; SUB ; AND ; OR ; MOV r3,r1
    limpa();
    imem[0] = 16'h540C;
    imem[1] = 16'h580A;
    imem[2] = 16'h2600;
    imem[3] = 16'h3600;
    imem[4] = 16'h4600;
    imem[5] = 16'h6D00;
    imem[6] = 16'hF000;
    reinicia();
    avancar(10);
    chk("sub_op_ula", 32'(bus.Op_ULA), 32'h1);
    avancar(4);
    chk("and_op_ula", 32'(bus.Op_ULA), 32'h2);
    avancar(4);
    chk("or_op_ula",  32'(bus.Op_ULA), 32'h3);
    avancar(4);
    chk("mov_op_ula", 32'(bus.Op_ULA), 32'h4);
    avancar(1);
    chk("mov_hab",      32'(bus.Hab_Escrita), 32'h1);
    chk("mov_sel_e_sa", 32'(bus.Sel_E_SA),    32'h3);
    chk("mov_sel_sb",   32'(bus.Sel_SB),      32'h1);
    avancar(1);
    chk("alu_r1", 32'(regs[1]), 32'hA);
    chk("alu_r3", 32'(regs[3]), 32'hA);

    // JMP 0x10
    limpa();
    imem[0]    = 16'h7010;
    imem[8'h10] = 16'hF000;
    reinicia();
    for (int k = 1; k <= 4; k++) begin
      chk("jmp_hab", 32'(bus.Hab_Escrita), 32'h0);
      avancar(1);
    end
    chk("jmp_endereco", 32'(bus.Endereco), 32'h10);

    // BEQZ r0,0x20 taken (r0 = 0) and not taken (r0 = 1)
    limpa();
    imem[0] = 16'h8020;
    reinicia();
    for (int k = 1; k <= 4; k++) begin
      chk("beqz_t_hab", 32'(bus.Hab_Escrita), 32'h0);
      avancar(1);
    end
    chk("beqz_taken_pc", 32'(bus.Endereco), 32'h20);
    r0_init = 16'h0001;
    reinicia();
    for (int k = 1; k <= 4; k++) begin
      chk("beqz_nt_hab", 32'(bus.Hab_Escrita), 32'h0);
      avancar(1);
    end
    chk("beqz_not_taken_pc", 32'(bus.Endereco), 32'h1);
    r0_init = 16'h0000;

    // HALT at PC=4: PARADO after its ESCRITA, then reset restarts
    limpa();
    imem[1] = 16'hA000;
    imem[4] = 16'hF000;
    reinicia();
    avancar(19);
    chk("halt_escrita_parado", 32'(bus.Parado),      32'h0);
    chk("halt_escrita_hab",    32'(bus.Hab_Escrita), 32'h0);
    avancar(1);
    chk("halt_parado",   32'(bus.Parado),   32'h1);
    chk("halt_endereco", 32'(bus.Endereco), 32'h4);
    for (int k = 0; k < 20; k++) begin
      avancar(1);
      if (bus.Parado !== 1'b1 || bus.Endereco !== 8'h04 || bus.Hab_Escrita !== 1'b0)
        chk("halt_hold", {bus.Hab_Escrita, bus.Parado, bus.Endereco}, {1'b0, 1'b1, 8'h04});
    end
    chk("halt_hold_end", {bus.Hab_Escrita, bus.Parado, bus.Endereco}, {1'b0, 1'b1, 8'h04});
    reinicia();
    chk("halt_rst_endereco", 32'(bus.Endereco), 32'h0);
    chk("halt_rst_parado",   32'(bus.Parado),   32'h0);

    // Reset during EXECUTA of ADD blocks the write
    limpa();
    imem[0] = 16'h1600;
    reinicia();
    avancar(2);
    chk("exec_sel_e_sa", 32'(bus.Sel_E_SA), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_exec_hab",      32'(bus.Hab_Escrita), 32'h0);
    chk("rst_exec_endereco", 32'(bus.Endereco),    32'h0);
    reset = 1'b0;
    cyc = 1;
    avancar(3);
    chk("restart_hab", 32'(bus.Hab_Escrita), 32'h1);

    // NOP chain across the PC wrap, with undefined opcode 0xA at 0xFF
    limpa();
    imem[0]     = 16'h70FE;
    imem[8'hFF] = 16'hA5FF;
    reinicia();
    avancar(4);
    chk("wrap_fe", 32'(bus.Endereco), 32'hFE);
    avancar(3);
    chk("nop_hab", 32'(bus.Hab_Escrita), 32'h0);
    avancar(1);
    chk("wrap_ff", 32'(bus.Endereco), 32'hFF);
    avancar(2);
    chk("undef_op_ula",   32'(bus.Op_ULA),   32'h0);
    chk("undef_imediato", 32'(bus.Imediato), 32'h0);
    chk("undef_sel_mux",  32'(bus.Sel_Mux),  32'h0);
    chk("undef_sel_e_sa", 32'(bus.Sel_E_SA), 32'h1);
    avancar(1);
    chk("undef_hab", 32'(bus.Hab_Escrita), 32'h0);
    avancar(1);
    chk("wrap_00", 32'(bus.Endereco), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
